// File: rtl/digit_uart_tx.sv
// digit_uart_tx: snapshots the 8-digit display buffer and decimal-point mask on a
// button press and streams it as ASCII over the UART txready/txclk handshake.
module digit_uart_tx #(
    parameter logic CRLF = 1'b1
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic            send,
    input  logic [7:0][3:0] digits,
    input  logic [7:0]      flt_pt,
    input  logic            txready,
    output logic [7:0]      txdata,
    output logic            txclk,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {StIdle, StChar, StStrobe, StGap, StDone} state_e;
    typedef enum logic [1:0] {PhDigit, PhDot, PhCr, PhLf} phase_e;

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [2:0]      pos_q, pos_d;
    logic            last_q, last_d;
    logic [7:0][3:0] snap_digits_q, snap_digits_d;
    logic [7:0]      snap_pt_q, snap_pt_d;
    logic [7:0]      txdata_q, txdata_d;
    logic            txclk_q, txclk_d;
    logic            send_meta_q, send_sync_q, send_dly_q;
    logic            start;
    logic [7:0]      cur_char;

    function automatic logic [7:0] hex_char(input logic [3:0] d);
        return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
    endfunction

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            send_meta_q <= 1'b0;
            send_sync_q <= 1'b0;
            send_dly_q  <= 1'b0;
        end else begin
            send_meta_q <= send;
            send_sync_q <= send_meta_q;
            send_dly_q  <= send_sync_q;
        end
    end

    // Rising edge of the synchronized button; a held button never retriggers.
    assign start = send_sync_q & ~send_dly_q;

    always_comb begin
        cur_char = 8'h00;
        unique case (phase_q)
            PhDigit: cur_char = hex_char(snap_digits_q[pos_q]);
            PhDot:   cur_char = 8'h2E;
            PhCr:    cur_char = 8'h0D;
            PhLf:    cur_char = 8'h0A;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        pos_d         = pos_q;
        last_d        = last_q;
        snap_digits_d = snap_digits_q;
        snap_pt_d     = snap_pt_q;
        txdata_d      = txdata_q;
        txclk_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snap_digits_d = digits;
                    snap_pt_d     = flt_pt;
                    pos_d         = 3'd7;
                    phase_d       = PhDigit;
                    last_d        = 1'b0;
                    txdata_d      = hex_char(digits[7]);
                    state_d       = StChar;
                end
            end
            StChar: begin
                if (txready) begin
                    txclk_d = 1'b1;
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                state_d = StGap;
                unique case (phase_q)
                    PhDigit, PhDot: begin
                        if (phase_q == PhDigit && snap_pt_q[pos_q]) begin
                            phase_d = PhDot;
                        end else if (pos_q != 3'd0) begin
                            pos_d   = pos_q - 3'd1;
                            phase_d = PhDigit;
                        end else if (CRLF) begin
                            phase_d = PhCr;
                        end else begin
                            last_d = 1'b1;
                        end
                    end
                    PhCr: phase_d = PhLf;
                    PhLf: last_d = 1'b1;
                endcase
            end
            StGap: begin
                if (last_q) begin
                    state_d = StDone;
                end else begin
                    txdata_d = cur_char;
                    state_d  = StChar;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q       <= StIdle;
            phase_q       <= PhDigit;
            pos_q         <= 3'd7;
            last_q        <= 1'b0;
            snap_digits_q <= '0;
            snap_pt_q     <= 8'h00;
            txdata_q      <= 8'h00;
            txclk_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            pos_q         <= pos_d;
            last_q        <= last_d;
            snap_digits_q <= snap_digits_d;
            snap_pt_q     <= snap_pt_d;
            txdata_q      <= txdata_d;
            txclk_q       <= txclk_d;
        end
    end

    assign txdata = txdata_q;
    assign txclk  = txclk_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_digit_uart_tx.sv
// Bench for digit_uart_tx: two instances (CR LF on / off) driven in lockstep and
// checked every cycle against a message model built from the buffer contents.
module tb_digit_uart_tx;

    logic            clk = 1'b0;
    logic            nrst;
    logic            send;
    logic [7:0][3:0] digits;
    logic [7:0]      flt_pt;
    logic            txready;
    logic [7:0]      td [2];
    logic            tc [2];
    logic            bz [2];
    logic            dn [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] exp_mem [2][32];
    int         exp_len [2];
    int         exp_idx [2];
    int         exp_done [2];
    int         done_cnt [2];
    logic [7:0] rx_mem [2][32];
    int         rx_cnt [2];
    logic [7:0] prev_td [2];
    logic       prev_done [2];
    int         last_cyc [2];
    bit         have_prev [2];
    bit         dropped [2];

    always #5 clk = ~clk;

    digit_uart_tx #(.CRLF(1'b1)) dut (
        .CLK(clk), .NRST(nrst), .send(send), .digits(digits), .flt_pt(flt_pt),
        .txready(txready), .txdata(td[0]), .txclk(tc[0]), .busy(bz[0]), .done(dn[0])
    );

    digit_uart_tx #(.CRLF(1'b0)) dut_nt (
        .CLK(clk), .NRST(nrst), .send(send), .digits(digits), .flt_pt(flt_pt),
        .txready(txready), .txdata(td[1]), .txclk(tc[1]), .busy(bz[1]), .done(dn[1])
    );

    function automatic string nm(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected message: hex digits left to right, '.' after flagged digits, optional CR LF.
    task automatic build_msg(input int i, input logic [7:0][3:0] dg, input logic [7:0] fp,
                             input bit crlf);
        string hexs = "0123456789ABCDEF";
        int n = 0;
        for (int p = 7; p >= 0; p--) begin
            exp_mem[i][n] = hexs[dg[p]];
            n++;
            if (fp[p]) begin
                exp_mem[i][n] = ".";
                n++;
            end
        end
        if (crlf) begin
            exp_mem[i][n] = 8'h0D;
            exp_mem[i][n+1] = 8'h0A;
            n += 2;
        end
        exp_len[i]  = n;
        exp_idx[i]  = 0;
        rx_cnt[i]   = 0;
        have_prev[i] = 1'b0;
        exp_done[i]++;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (nrst) begin
            for (int i = 0; i < 2; i++) begin
                if (!txready) dropped[i] = 1'b1;
                if (tc[i]) begin
                    chk(nm("strobe_busy", i), 32'(bz[i]), 32'd1);
                    chk(nm("strobe_ready", i), 32'(txready), 32'd1);
                    chk(nm("strobe_stable", i), 32'(td[i]), 32'(prev_td[i]));
                    chk(nm("strobe_in_msg", i), 32'(exp_idx[i] < exp_len[i]), 32'd1);
                    if (exp_idx[i] < exp_len[i])
                        chk(nm("byte", i), 32'(td[i]), 32'(exp_mem[i][exp_idx[i]]));
                    if (have_prev[i] && !dropped[i])
                        chk(nm("spacing", i), 32'(cyc - last_cyc[i]), 32'd3);
                    if (rx_cnt[i] < 32) begin
                        rx_mem[i][rx_cnt[i]] = td[i];
                        rx_cnt[i]++;
                    end
                    exp_idx[i]++;
                    last_cyc[i]  = cyc;
                    have_prev[i] = 1'b1;
                    dropped[i]   = 1'b0;
                end
                if (dn[i]) begin
                    chk(nm("done_busy", i), 32'(bz[i]), 32'd1);
                    chk(nm("done_all_sent", i), 32'(exp_idx[i]), 32'(exp_len[i]));
                    chk(nm("done_after_gap", i), 32'(cyc - last_cyc[i]), 32'd2);
                    done_cnt[i]++;
                    have_prev[i] = 1'b0;
                end
                if (prev_done[i]) chk(nm("busy_fall", i), 32'(bz[i]), 32'd0);
                prev_td[i]   = td[i];
                prev_done[i] = dn[i];
            end
        end
    end

    task automatic press(input int hold);
        build_msg(0, digits, flt_pt, 1'b1);
        build_msg(1, digits, flt_pt, 1'b0);
        @(negedge clk);
        #1 send = 1'b1;
        @(negedge clk);
        chk("lat_busy_k1", 32'(bz[0]), 32'd0);
        @(negedge clk);
        chk("lat_busy_k2", 32'(bz[0]), 32'd0);
        @(negedge clk);
        chk("lat_busy_k3", 32'(bz[0]), 32'd1);
        chk("lat_first_char", 32'(td[0]), 32'(exp_mem[0][0]));
        chk("lat_first_char_nt", 32'(td[1]), 32'(exp_mem[1][0]));
        for (int c = 3; c < hold; c++) @(negedge clk);
        #1 send = 1'b0;
    endtask

    task automatic wait_done();
        int c = 0;
        while ((done_cnt[0] < exp_done[0] || done_cnt[1] < exp_done[1]) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("done_count0", 32'(done_cnt[0]), 32'(exp_done[0]));
        chk("done_count1", 32'(done_cnt[1]), 32'(exp_done[1]));
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] basic_exp [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h2E,
                                   8'h43, 8'h44, 8'h0D, 8'h0A};

    initial begin
        bit found;
        nrst    = 1'b0;
        send    = 1'b0;
        txready = 1'b1;
        digits  = 32'h1234ABCD;
        flt_pt  = 8'h04;
        for (int i = 0; i < 2; i++) begin
            exp_len[i] = 0; exp_idx[i] = 0; exp_done[i] = 0; done_cnt[i] = 0;
            rx_cnt[i] = 0; prev_td[i] = 8'h00; prev_done[i] = 1'b0; last_cyc[i] = 0;
            have_prev[i] = 1'b0; dropped[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(nm("rst_txdata", i), 32'(td[i]), 32'h00);
            chk(nm("rst_txclk", i), 32'(tc[i]), 32'd0);
            chk(nm("rst_busy", i), 32'(bz[i]), 32'd0);
            chk(nm("rst_done", i), 32'(dn[i]), 32'd0);
        end
        #1 nrst = 1'b1;

        // Basic transfer
        press(3);
        wait_done();
        chk("basic_len", 32'(rx_cnt[0]), 32'd11);
        for (int k = 0; k < 11; k++) chk("basic_lit", 32'(rx_mem[0][k]), 32'(basic_exp[k]));
        chk("basic_len_nt", 32'(rx_cnt[1]), 32'd9);
        chk("basic_lit_nt_last", 32'(rx_mem[1][8]), 32'h44);

        // All dots, max length with terminator on dut
        digits = '0;
        flt_pt = 8'hFF;
        press(3);
        wait_done();
        chk("dots_len_nt", 32'(rx_cnt[1]), 32'd16);
        chk("dots_nt_0", 32'(rx_mem[1][0]), 32'h30);
        chk("dots_nt_1", 32'(rx_mem[1][1]), 32'h2E);
        chk("dots_nt_15", 32'(rx_mem[1][15]), 32'h2E);
        chk("dots_len", 32'(rx_cnt[0]), 32'd18);
        chk("dots_cr", 32'(rx_mem[0][16]), 32'h0D);
        chk("dots_lf", 32'(rx_mem[0][17]), 32'h0A);

        // Backpressure on byte 3
        digits = 32'h1234ABCD;
        flt_pt = 8'h04;
        press(3);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (td[0] == 8'h33 && !tc[0]) found = 1'b1;
        end
        chk("bp_found", 32'(found), 32'd1);
        #1 txready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold_txclk", 32'(tc[0]), 32'd0);
            chk("bp_hold_txdata", 32'(td[0]), 32'h33);
        end
        #1 txready = 1'b1;
        @(negedge clk);
        chk("bp_resume", 32'(tc[0]), 32'd1);
        chk("bp_resume_data", 32'(td[0]), 32'h33);
        wait_done();
        chk("bp_len", 32'(rx_cnt[0]), 32'd11);

        // Snapshot isolation and retrigger while busy
        press(3);
        repeat (8) @(negedge clk);
        #1 digits = 32'hFFFFFFFF;
        send = 1'b1;
        repeat (4) @(negedge clk);
        #1 send = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        chk("retrig_done0", 32'(done_cnt[0]), 32'(exp_done[0]));
        chk("retrig_len", 32'(rx_cnt[0]), 32'd11);
        chk("snap_b", 32'(rx_mem[0][5]), 32'h42);
        chk("snap_d", 32'(rx_mem[0][8]), 32'h44);

        // Held button: one message, then a fresh press gives another
        digits = 32'h1234ABCD;
        press(200);
        wait_done();
        repeat (20) @(negedge clk);
        chk("held_done0", 32'(done_cnt[0]), 32'(exp_done[0]));
        press(3);
        wait_done();
        chk("held_second_len", 32'(rx_cnt[0]), 32'd11);

        // Reset during a strobe
        press(3);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (tc[0] && td[0] == 8'h33) found = 1'b1;
        end
        chk("rst_strobe_found", 32'(found), 32'd1);
        #1 nrst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(nm("midrst_txclk", i), 32'(tc[i]), 32'd0);
            chk(nm("midrst_busy", i), 32'(bz[i]), 32'd0);
            chk(nm("midrst_done", i), 32'(dn[i]), 32'd0);
            chk(nm("midrst_txdata", i), 32'(td[i]), 32'h00);
            exp_len[i] = 0; exp_idx[i] = 0; have_prev[i] = 1'b0; prev_done[i] = 1'b0;
            exp_done[i]--;
        end
        repeat (3) @(negedge clk);
        #1 nrst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(bz[0]), 32'd0);
        end
        press(3);
        wait_done();
        chk("post_rst_len", 32'(rx_cnt[0]), 32'd11);
        chk("post_rst_first", 32'(rx_mem[0][0]), 32'h31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
